// File: rtl/can_acf_sequencer_if.sv
// Frame-header handshake between the bit-stream processor (master) and the
// acceptance-filter sequencer (slave).
interface can_acf_sequencer_if;
  logic        start;
  logic        abort;
  logic [28:0] rx_id;
  logic        rx_ide;
  logic        rx_rtr;
  logic [3:0]  rx_dlc;
  logic [7:0]  rx_data0;
  logic [7:0]  rx_data1;
  logic        busy;
  logic        result_valid;
  logic        id_ok;

  modport master (
    output start, abort, rx_id, rx_ide, rx_rtr, rx_dlc, rx_data0, rx_data1,
    input  busy, result_valid, id_ok
  );

  modport slave (
    input  start, abort, rx_id, rx_ide, rx_rtr, rx_dlc, rx_data0, rx_data1,
    output busy, result_valid, id_ok
  );
endinterface

// File: rtl/can_acf_sequencer.sv
// SJA1000-style acceptance filter evaluated one byte lane per cycle through a
// single shared masked comparator; result after a fixed four-step sweep.
module can_acf_sequencer (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reset_mode,
  input  logic                 extended_mode,
  input  logic                 acceptance_filter_mode,
  input  logic [7:0]           acr0,
  input  logic [7:0]           acr1,
  input  logic [7:0]           acr2,
  input  logic [7:0]           acr3,
  input  logic [7:0]           amr0,
  input  logic [7:0]           amr1,
  input  logic [7:0]           amr2,
  input  logic [7:0]           amr3,
  can_acf_sequencer_if.slave   rx
);

  typedef enum logic {IDLE, EVAL} state_t;

  state_t      state;
  logic [1:0]  s;
  logic [28:0] id_q;
  logic        ide_q;
  logic        rtr_q;
  logic [3:0]  dlc_q;
  logic [7:0]  data0_q;
  logic [7:0]  data1_q;
  logic        f1_ok;
  logic        f2_ok;
  logic        busy_q;
  logic        result_valid_q;
  logic        id_ok_q;

  logic [7:0]  lane;
  logic [7:0]  valid;
  logic [7:0]  f2_sel;
  logic [7:0]  acr_s;
  logic [7:0]  amr_s;
  logic [7:0]  mis;
  logic        d0_present;
  logic        d1_present;
  logic        dual;
  logic        f1_hit;
  logic        f2_hit;
  logic        f1_next;
  logic        f2_next;

  assign d0_present = !rtr_q && (dlc_q != 4'd0);
  assign d1_present = !rtr_q && (dlc_q >= 4'd2);
  assign dual       = extended_mode && !acceptance_filter_mode;

  always_comb begin
    acr_s = acr0;
    amr_s = amr0;
    case (s)
      2'd0: begin acr_s = acr0; amr_s = amr0; end
      2'd1: begin acr_s = acr1; amr_s = amr1; end
      2'd2: begin acr_s = acr2; amr_s = amr2; end
      2'd3: begin acr_s = acr3; amr_s = amr3; end
      default: begin acr_s = acr0; amr_s = amr0; end
    endcase
  end

  // Lane mux: which header bits are compared at step s, which of them are
  // relevant, and which belong to the second filter in dual mode.
  always_comb begin
    lane   = 8'h00;
    valid  = 8'h00;
    f2_sel = 8'h00;
    if (!extended_mode) begin
      if (s == 2'd0) begin
        lane  = id_q[10:3];
        valid = 8'hFF;
      end
    end else if (!dual) begin
      if (ide_q) begin
        valid = 8'hFF;
        case (s)
          2'd0: lane = id_q[28:21];
          2'd1: lane = id_q[20:13];
          2'd2: lane = id_q[12:5];
          2'd3: begin lane = {id_q[4:0], rtr_q, 2'b00}; valid = 8'hFC; end
          default: lane = 8'h00;
        endcase
      end else begin
        case (s)
          2'd0: begin lane = id_q[10:3]; valid = 8'hFF; end
          2'd1: begin lane = {id_q[2:0], rtr_q, 4'h0}; valid = 8'hF0; end
          2'd2: begin lane = data0_q; valid = {8{d0_present}}; end
          2'd3: begin lane = data1_q; valid = {8{d1_present}}; end
          default: lane = 8'h00;
        endcase
      end
    end else begin
      if (ide_q) begin
        valid = 8'hFF;
        case (s)
          2'd0: lane = id_q[28:21];
          2'd1: lane = id_q[20:13];
          2'd2: begin lane = id_q[28:21]; f2_sel = 8'hFF; end
          2'd3: begin lane = id_q[20:13]; f2_sel = 8'hFF; end
          default: lane = 8'h00;
        endcase
      end else begin
        case (s)
          2'd0: begin lane = id_q[10:3]; valid = 8'hFF; end
          2'd1: begin
            lane  = {id_q[2:0], rtr_q, data0_q[7:4]};
            valid = {4'hF, {4{d0_present}}};
          end
          2'd2: begin lane = id_q[10:3]; valid = 8'hFF; f2_sel = 8'hFF; end
          2'd3: begin
            lane   = {id_q[2:0], rtr_q, data0_q[3:0]};
            valid  = {4'hF, {4{d0_present}}};
            f2_sel = 8'hF0;
          end
          default: lane = 8'h00;
        endcase
      end
    end
  end

  assign mis     = (lane ^ acr_s) & ~amr_s & valid;
  assign f1_hit  = |(mis & ~f2_sel);
  assign f2_hit  = |(mis & f2_sel);
  assign f1_next = f1_ok & ~f1_hit;
  assign f2_next = f2_ok & ~f2_hit;

  // Abort and reset mode both drop the evaluation without a result pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      s              <= 2'd0;
      f1_ok          <= 1'b0;
      f2_ok          <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      id_ok_q        <= 1'b0;
      id_q           <= '0;
      ide_q          <= 1'b0;
      rtr_q          <= 1'b0;
      dlc_q          <= 4'h0;
      data0_q        <= 8'h00;
      data1_q        <= 8'h00;
    end else if (reset_mode) begin
      state          <= IDLE;
      s              <= 2'd0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      id_ok_q        <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rx.abort) begin
            id_ok_q <= 1'b0;
          end else if (rx.start) begin
            state   <= EVAL;
            busy_q  <= 1'b1;
            s       <= 2'd0;
            f1_ok   <= 1'b1;
            f2_ok   <= 1'b1;
            id_ok_q <= 1'b0;
            id_q    <= rx.rx_id;
            ide_q   <= rx.rx_ide;
            rtr_q   <= rx.rx_rtr;
            dlc_q   <= rx.rx_dlc;
            data0_q <= rx.rx_data0;
            data1_q <= rx.rx_data1;
          end
        end
        EVAL: begin
          if (rx.abort) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            s       <= 2'd0;
            id_ok_q <= 1'b0;
          end else begin
            f1_ok <= f1_next;
            f2_ok <= f2_next;
            s     <= s + 2'd1;
            if (s == 2'd3) begin
              state          <= IDLE;
              busy_q         <= 1'b0;
              result_valid_q <= 1'b1;
              id_ok_q        <= dual ? (f1_next | f2_next) : f1_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx.busy         = busy_q;
  assign rx.result_valid = result_valid_q;
  assign rx.id_ok        = id_ok_q;

endmodule

// File: tb/tb_can_acf_sequencer.sv
// Bench for can_acf_sequencer: directed scenarios plus random frames scored
// against a whole-word acceptance model.
module tb_can_acf_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reset_mode;
  logic        extended_mode;
  logic        afm;
  logic [7:0]  acr0, acr1, acr2, acr3;
  logic [7:0]  amr0, amr1, amr2, amr3;
  logic        start, abort;
  logic [28:0] hdr_id;
  logic        hdr_ide, hdr_rtr;
  logic [3:0]  hdr_dlc;
  logic [7:0]  hdr_d0, hdr_d1;

  int n_checks = 0;
  int n_fail   = 0;

  can_acf_sequencer_if bus ();

  assign bus.start    = start;
  assign bus.abort    = abort;
  assign bus.rx_id    = hdr_id;
  assign bus.rx_ide   = hdr_ide;
  assign bus.rx_rtr   = hdr_rtr;
  assign bus.rx_dlc   = hdr_dlc;
  assign bus.rx_data0 = hdr_d0;
  assign bus.rx_data1 = hdr_d1;

  can_acf_sequencer dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .reset_mode             (reset_mode),
    .extended_mode          (extended_mode),
    .acceptance_filter_mode (afm),
    .acr0                   (acr0),
    .acr1                   (acr1),
    .acr2                   (acr2),
    .acr3                   (acr3),
    .amr0                   (amr0),
    .amr1                   (amr1),
    .amr2                   (amr2),
    .amr3                   (amr3),
    .rx                     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit masked_eq(input logic [31:0] w, input logic [31:0] c,
                                   input logic [31:0] m, input logic [31:0] r);
    return ((w ^ c) & ~m & r) == 32'h0;
  endfunction

  // Each filter is a code/mask match over a whole concatenated field word.
  function automatic bit model_accept();
    logic [31:0] cw;
    logic [31:0] mw;
    bit p0, p1, f1, f2;
    cw = {acr0, acr1, acr2, acr3};
    mw = {amr0, amr1, amr2, amr3};
    p0 = !hdr_rtr && (hdr_dlc >= 4'd1);
    p1 = !hdr_rtr && (hdr_dlc >= 4'd2);
    if (!extended_mode)
      return masked_eq({hdr_id[10:3], 24'h0}, cw, mw, 32'hFF00_0000);
    if (afm) begin
      if (hdr_ide)
        return masked_eq({hdr_id, hdr_rtr, 2'b00}, cw, mw, 32'hFFFF_FFFC);
      return masked_eq({hdr_id[10:0], hdr_rtr, 4'h0, hdr_d0, hdr_d1}, cw, mw,
                       {12'hFFF, 4'h0, p0 ? 8'hFF : 8'h00, p1 ? 8'hFF : 8'h00});
    end
    if (hdr_ide) begin
      f1 = masked_eq({hdr_id[28:13], 16'h0}, {acr0, acr1, 16'h0}, {amr0, amr1, 16'h0}, 32'hFFFF_0000);
      f2 = masked_eq({hdr_id[28:13], 16'h0}, {acr2, acr3, 16'h0}, {amr2, amr3, 16'h0}, 32'hFFFF_0000);
    end else begin
      f1 = masked_eq({hdr_id[10:0], hdr_rtr, hdr_d0, 12'h0},
                     {acr0, acr1, acr3[3:0], 12'h0}, {amr0, amr1, amr3[3:0], 12'h0},
                     {12'hFFF, p0 ? 8'hFF : 8'h00, 12'h0});
      f2 = masked_eq({hdr_id[10:0], hdr_rtr, 20'h0},
                     {acr2, acr3[7:4], 20'h0}, {amr2, amr3[7:4], 20'h0},
                     {12'hFFF, 20'h0});
    end
    return f1 | f2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input logic [28:0] id, input logic ide, input logic rtr,
                           input logic [3:0] dlc, input logic [7:0] d0, input logic [7:0] d1);
    hdr_id  = id;
    hdr_ide = ide;
    hdr_rtr = rtr;
    hdr_dlc = dlc;
    hdr_d0  = d0;
    hdr_d1  = d1;
  endtask

  task automatic set_filters(input logic [31:0] code, input logic [31:0] mask);
    {acr0, acr1, acr2, acr3} = code;
    {amr0, amr1, amr2, amr3} = mask;
  endtask

  task automatic launch(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s busy after start: got %b want 1", name, bus.busy);
    end
  endtask

  task automatic wait_result(input bit exp, input string name);
    int lat;
    bit seen;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 12) begin
      tick();
      lat++;
      if (bus.result_valid === 1'b1) begin
        seen = 1;
      end else if (lat < 4) begin
        n_checks++;
        if (bus.busy !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL %s busy during eval cycle %0d: got %b want 1", name, lat, bus.busy);
        end
      end
    end
    n_checks++;
    if (!seen || lat != 4) begin
      n_fail++;
      $display("[TB] FAIL %s latency: got %0d (seen=%0d) want 4", name, lat, seen);
    end
    if (seen) begin
      n_checks++;
      if (bus.id_ok !== exp) begin
        n_fail++;
        $display("[TB] FAIL %s id_ok: got %b want %b", name, bus.id_ok, exp);
      end
      n_checks++;
      if (bus.busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL %s busy at result: got %b want 0", name, bus.busy);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if ({bus.busy, bus.result_valid, bus.id_ok} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL %s busy/result_valid/id_ok: got %b%b%b want 000",
               name, bus.busy, bus.result_valid, bus.id_ok);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_basic();
    extended_mode = 1'b0;
    afm           = 1'b0;
    set_filters(32'hA500_0000, 32'h0000_0000);
    set_frame(29'h52F, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    launch("basic_match");
    wait_result(1'b1, "basic_match");
    tick();
    n_checks++;
    if (bus.result_valid !== 1'b0 || bus.id_ok !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL basic_hold rv/id_ok: got %b/%b want 0/1", bus.result_valid, bus.id_ok);
    end
    set_frame(29'h537, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    launch("basic_miss");
    wait_result(1'b0, "basic_miss");
  endtask

  task automatic test_single_ext();
    extended_mode = 1'b1;
    afm           = 1'b1;
    set_filters(32'h1234_5678, 32'h0000_0003);
    set_frame(29'h0246_8ACF, 1'b1, 1'b0, 4'd8, 8'h11, 8'h22);
    launch("single_ext_match");
    wait_result(1'b1, "single_ext_match");
    set_frame(29'h0246_8ACE, 1'b1, 1'b0, 4'd8, 8'h11, 8'h22);
    launch("single_ext_bit0");
    wait_result(1'b0, "single_ext_bit0");
  endtask

  task automatic test_single_std();
    extended_mode = 1'b1;
    afm           = 1'b1;
    set_filters(32'hA5E0_FFFF, 32'h0000_0000);
    set_frame(29'h52F, 1'b0, 1'b0, 4'd0, 8'h00, 8'hFF);
    launch("single_std_dlc0");
    wait_result(1'b1, "single_std_dlc0");
    set_frame(29'h52F, 1'b0, 1'b0, 4'd2, 8'h00, 8'hFF);
    launch("single_std_dlc2");
    wait_result(1'b0, "single_std_dlc2");
    set_frame(29'h52F, 1'b0, 1'b1, 4'd2, 8'h00, 8'h00);
    acr1 = 8'hF0;
    launch("single_std_rtr");
    wait_result(1'b1, "single_std_rtr");
  endtask

  task automatic test_dual_std();
    extended_mode = 1'b1;
    afm           = 1'b0;
    set_frame(29'h52F, 1'b0, 1'b0, 4'd1, 8'h3C, 8'h00);
    set_filters(32'h00E3_A5EC, 32'h0000_0000);
    launch("dual_f2_only");
    wait_result(1'b1, "dual_f2_only");
    set_filters(32'h00E3_00EC, 32'h0000_0000);
    launch("dual_none");
    wait_result(1'b0, "dual_none");
    set_filters(32'hA5E3_A56C, 32'h0000_0000);
    launch("dual_l3hi_f1ok");
    wait_result(1'b1, "dual_l3hi_f1ok");
    set_filters(32'h00E3_A56C, 32'h0000_0000);
    launch("dual_l3hi_f1bad");
    wait_result(1'b0, "dual_l3hi_f1bad");
  endtask

  task automatic test_abort();
    extended_mode = 1'b0;
    set_filters(32'hA500_0000, 32'h0000_0000);
    set_frame(29'h52F, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    launch("abort_run");
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_outputs("abort_step2");
    launch("after_abort");
    wait_result(1'b1, "after_abort");
  endtask

  task automatic test_back_to_back();
    int pulses;
    int pulse_at;
    logic pulse_ok;
    extended_mode = 1'b0;
    set_filters(32'hA500_0000, 32'h0000_0000);
    set_frame(29'h52F, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    launch("b2b_first");
    tick();
    set_frame(29'h537, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses   = 0;
    pulse_at = -1;
    pulse_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.result_valid === 1'b1) begin
        pulses++;
        pulse_at = i;
        pulse_ok = bus.id_ok;
      end
    end
    n_checks++;
    if (pulses != 1 || pulse_at != 1) begin
      n_fail++;
      $display("[TB] FAIL b2b_pulses: got %0d at %0d want 1 at 1", pulses, pulse_at);
    end
    n_checks++;
    if (pulse_ok !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_first_id_ok: got %b want 1", pulse_ok);
    end
    launch("chain_a");
    wait_result(1'b0, "chain_a");
    set_frame(29'h52F, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    launch("chain_b_same_cycle");
    wait_result(1'b1, "chain_b_same_cycle");
  endtask

  task automatic test_reset_mode();
    int pulses;
    launch("rmode_run");
    tick();
    reset_mode = 1'b1;
    tick();
    check_idle_outputs("rmode_mid_eval");
    start = 1'b1;
    tick();
    start = 1'b0;
    check_idle_outputs("rmode_start_ignored");
    reset_mode = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.result_valid === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("[TB] FAIL rmode_no_result: got %0d active cycles want 0", pulses);
    end
    launch("rst_mid_eval");
    tick();
    rst_n = 1'b0;
    tick();
    check_idle_outputs("rst_mid_eval");
    rst_n = 1'b1;
    tick();
    check_idle_outputs("rst_mid_eval_after");
  endtask

  task automatic test_random();
    logic [31:0] mask;
    bit exp;
    for (int t = 0; t < 60; t++) begin
      extended_mode = 1'($urandom_range(0, 1));
      afm           = 1'($urandom_range(0, 1));
      mask = $urandom;
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) mask = mask | $urandom;
      set_filters($urandom, mask);
      set_frame(29'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                4'($urandom_range(0, 8)), 8'($urandom), 8'($urandom));
      exp = model_accept();
      launch("random");
      wait_result(exp, "random");
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    reset_mode    = 1'b0;
    extended_mode = 1'b0;
    afm           = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    set_filters(32'h0, 32'h0);
    set_frame(29'h0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    test_reset();
    test_basic();
    test_single_ext();
    test_single_std();
    test_dual_std();
    test_abort();
    test_back_to_back();
    test_reset_mode();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/can_acf_sequencer.md
# can_acf_sequencer

Sequential acceptance-filter engine for the SJA1000-compatible CAN controller. It latches a received frame header when the bit-stream processor asserts `start`. It then evaluates the header against acceptance code/mask registers ACR0..3/AMR0..3 through a single shared 8-bit masked comparator, one byte lane per cycle. It supports basic mode, extended single-filter mode and extended dual-filter mode. The result is `id_ok`, which gates RX FIFO writes.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `reset_mode`  in  1  controller reset mode; forces idle.
- `extended_mode`  in  1  0 = basic mode, 1 = PeliCAN mode.
- `acceptance_filter_mode`  in  1  1 = single filter, 0 = dual filter; ignored in basic mode.
- `acr0`..`acr3`  in  8 each  acceptance code bytes.
- `amr0`..`amr3`  in  8 each  acceptance mask bytes; mask bit 1 = don't care.
- `start`  in  1  one-cycle pulse; header inputs are valid in that cycle.
- `abort`  in  1  bus error or arbitration loss; cancels the evaluation.
- `rx_id`  in  29  identifier; a standard ID occupies `rx_id[10:0]`.
- `rx_ide`, `rx_rtr`  in  1 each  extended-frame flag, remote-frame flag.
- `rx_dlc`  in  4  data length code.
- `rx_data0`, `rx_data1`  in  8 each  first two data bytes.
- `busy`  out  1  evaluation in progress.
- `result_valid`  out  1  one-cycle pulse when `id_ok` is updated.
- `id_ok`  out  1  frame accepted; level, held until the next accepted start or abort.

## Operation
- States are IDLE and EVAL; a 2-bit step counter `s` runs 0..3.
- IDLE → EVAL on `start`=1 when `reset_mode`=0. In that cycle the block latches the header fields, clears `id_ok`, sets `f1_ok`=1 and `f2_ok`=1, and sets `s`=0.
- In EVAL, each cycle computes `mis` = (L_s ^ acr_s) & ~amr_s & V_s. V_s is the relevant-bit mask for lane s.
  - Filter-1 bits of `mis` that are nonzero clear `f1_ok`.
  - Filter-2 bits of `mis` that are nonzero clear `f2_ok`.
  - At `s`=3, the block goes to IDLE, pulses `result_valid` and loads `id_ok`.
- `id_ok` = `f1_ok` in basic and single-filter modes; `f1_ok`|`f2_ok` in dual-filter mode. The value includes step-3 mismatches.
- A data byte or nibble is "absent" if `rx_rtr`=1, or if `rx_dlc` is below the byte index+1. Absent bits have V=0.
- Lane map (all bits filter 1 unless stated):
  - Basic mode: L0 = `id[10:3]`; V1..V3 = 0.
  - Single filter, standard frame:
    - L0 = `id[10:3]`.
    - L1 = {`id[2:0]`, `rtr`, 4'b0}, with V1[3:0] = 0.
    - L2 = `data0`.
    - L3 = `data1`.
  - Single filter, extended frame:
    - L0 = `id[28:21]`, L1 = `id[20:13]`, L2 = `id[12:5]`.
    - L3 = {`id[4:0]`, `rtr`, 2'b0}, with V3[1:0] = 0.
  - Dual filter, standard frame:
    - L0 = `id[10:3]`.
    - L1 = {`id[2:0]`, `rtr`, `data0[7:4]`}.
    - L2 = `id[10:3]` (filter 2).
    - L3 = {`id[2:0]`, `rtr`, `data0[3:0]`}. L3[7:4] goes to filter 2; L3[3:0] goes to filter 1.
  - Dual filter, extended frame:
    - L0 = `id[28:21]`, L1 = `id[20:13]`.
    - L2 = `id[28:21]` (filter 2), L3 = `id[20:13]` (filter 2).
- Mode inputs and ACR/AMR are read live each step; software changes them only in reset mode.

## Timing
- Reset values: state IDLE, `busy`=0, `result_valid`=0, `id_ok`=0, `s`=0, `f1_ok`=0, `f2_ok`=0.
- If `start` is sampled at edge E0, then EVAL steps occur at edges E1..E4.
  - `busy`=1 from after E0 through E4.
  - `result_valid`=1 and the new `id_ok` appear for exactly one cycle after E4.
  - The fixed latency is therefore 4 cycles.
- A `start` while busy is ignored; the running evaluation is unaffected.
- A `start` in the same cycle as `result_valid` is accepted.
- An `abort` sampled while busy moves the block to IDLE with `busy`=0 and `id_ok`=0, and no `result_valid`. `abort` wins over a simultaneous `start`.
- When `reset_mode`=1, the block is forced to IDLE, `id_ok`=0 and `result_valid`=0, and `start` is ignored. The same holds mid-EVAL.
- `rst_n`=0 mid-EVAL returns all outputs to their reset values at the next edge.

## Test plan
- Basic mode, `acr0`=8'hA5, `amr0`=8'h00, std ID 11'h52F (`id[10:3]`=8'hA5), start → `result_valid` 4 cycles later, `id_ok`=1. ID 11'h537 → `id_ok`=0.
- Single filter, ext frame, ACR={8'h12,8'h34,8'h56,8'h78}, AMR=8'h00 except `amr3`=8'h03, ID 29'h02468ACF with `rtr`=0 → `id_ok`=1. Flipping ID bit 0 → `id_ok`=0.
- Single filter, std frame, DLC=0, `acr2`/`acr3`=8'hFF, `amr`=8'h00, header matches → `id_ok`=1 (absent data ignored). With DLC=2 and `data0`=8'h00 → `id_ok`=0.
- Dual filter, std frame:
  - Filter 1 mismatches, filter 2 matches → `id_ok`=1.
  - Both filters mismatch → `id_ok`=0.
  - Filter-2 mismatch only in L3[7:4] → `id_ok` follows filter 1.
- Abort at step 2 → no `result_valid`, `busy`=0 next cycle, `id_ok`=0. A new start 1 cycle later completes normally.
- Start, then a second start at step 1 → only one `result_valid`, for the first frame. Then `reset_mode`=1 mid-EVAL → idle, no result.
